// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard inputs and IF/ID/PC control outputs.
//   idRs/idRt/idUsesRt/idMulDiv : instruction currently in ID
//   exMemRead/exRd              : instruction currently in EX
//   branchTaken                 : EX resolved a taken branch/jump
//   PCWrite/IFIDWrite/IFFlush/IDEXFlush : pipeline control
//   stallCount                  : stall-cycle counter (zero unless enabled)
// slave = hazard controller side, master = pipeline side.
interface hazard_ctrl_if #(parameter int REG_AW = 4);
  logic [REG_AW-1:0] idRs, idRt, exRd;
  logic              idUsesRt, idMulDiv, exMemRead, branchTaken;
  logic              PCWrite, IFIDWrite, IFFlush, IDEXFlush;
  logic [15:0]       stallCount;

  modport slave (
    input  idRs, idRt, idUsesRt, idMulDiv, exMemRead, exRd, branchTaken,
    output PCWrite, IFIDWrite, IFFlush, IDEXFlush, stallCount
  );
  modport master (
    output idRs, idRt, idUsesRt, idMulDiv, exMemRead, exRd, branchTaken,
    input  PCWrite, IFIDWrite, IFFlush, IDEXFlush, stallCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 16-bit 5-stage core.
// Sequences load-use stalls, multi-cycle mul/div stalls and taken-branch
// flushes. Controls are combinational from registered state/cnt plus the
// current inputs, so IF/ID, ID/EX and PC act on the same edge.
// Ports: clk, rst_n (async active-low), hif (hazard_ctrl_if.slave).
// Optional: define HAZARD_STALL_COUNT_EN to build the saturating 16-bit
// stall-cycle counter on hif.stallCount; otherwise it is tied to zero.
module hazard_ctrl #(
  parameter int REG_AW       = 4,
  parameter int MD_CYCLES    = 4,   // 1..15
  parameter int FLUSH_CYCLES = 1    // 1..3
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hif
);
  typedef enum logic [1:0] {RUN, MD_WAIT, FLUSH} state_e;

  localparam logic [3:0] MD_INIT = 4'(MD_CYCLES - 1);
  localparam logic [3:0] FL_INIT = 4'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu;

  // r0 never carries a real dependency; rt only matters if it is read.
  assign lu = hif.exMemRead && (hif.exRd != {REG_AW{1'b0}}) &&
              ((hif.exRd == hif.idRs) || (hif.idUsesRt && (hif.exRd == hif.idRt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hif.branchTaken) begin
      // A taken branch restarts the flush and abandons any mul/div wait.
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FL_INIT;
      end else begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    end else begin
      case (state_q)
        RUN: begin
          // LU wins over mul/div; the mul/div is seen again after the bubble.
          if (!lu && hif.idMulDiv && (MD_CYCLES > 1)) begin
            state_d = MD_WAIT;
            cnt_d   = MD_INIT;
          end
        end
        MD_WAIT, FLUSH: begin
          if (cnt_q == 4'd1) begin
            state_d = RUN;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    hif.PCWrite   = 1'b1;
    hif.IFIDWrite = 1'b1;
    hif.IFFlush   = 1'b0;
    hif.IDEXFlush = 1'b0;
    if (!rst_n) begin
      // Hold PC and keep flushing so the reset-less IF/ID clears on edges.
      hif.PCWrite   = 1'b0;
      hif.IFIDWrite = 1'b0;
      hif.IFFlush   = 1'b1;
      hif.IDEXFlush = 1'b1;
    end else if (hif.branchTaken || (state_q == FLUSH)) begin
      hif.IFFlush   = 1'b1;
      hif.IDEXFlush = 1'b1;
    end else if ((state_q == MD_WAIT) || lu) begin
      hif.PCWrite   = 1'b0;
      hif.IFIDWrite = 1'b0;
      hif.IDEXFlush = 1'b1;
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Flush cycles keep PCWrite=1, so only real stalls are counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!hif.PCWrite && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 16'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign hif.stallCount = stall_cnt_q;
`else
  assign hif.stallCount = 16'h0000;
`endif
endmodule
